// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one recoding step per clock, W1 = WIDTH+1 steps per product.
// Operands and product pass through valid/ready handshakes; the product is held under backpressure.
module booth_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 op_signed_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);
    localparam int W1 = WIDTH + 1;
    localparam int AW = W1 + 1;       // guard bit keeps -M representable for M = -2^WIDTH
    localparam int CW = $clog2(W1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [W1-1:0]        q_q, q_d;
    logic                 e_q, e_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [AW-1:0]        sum;
    logic                 ext_a;
    logic                 ext_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            e_q     <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            e_q     <= e_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        e_d     = e_q;
        prod_d  = prod_q;
        sum     = acc_q;
        ext_a   = op_signed_i & a_i[WIDTH-1];
        ext_b   = op_signed_i & b_i[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    m_d     = {{2{ext_a}}, a_i};
                    acc_d   = '0;
                    q_d     = {ext_b, b_i};
                    e_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                case ({q_q[0], e_q})
                    2'b10:   sum = acc_q - m_q;
                    2'b01:   sum = acc_q + m_q;
                    default: sum = acc_q;
                endcase
                acc_d = {sum[AW-1], sum[AW-1:1]};
                q_d   = {sum[0], q_q[W1-1:1]};
                e_d   = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W1 - 1)) begin
                    // Full 2*W1-bit product is {acc[W1-1:0], q}; keep its low 2*WIDTH bits.
                    prod_d  = {acc_d[WIDTH-2:0], q_d};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
    assign product_o   = prod_q;

endmodule
